operand_loader: RTL and testbench

Sequential operand-entry stage sitting directly upstream of the signed 4-bit adder on the board. Captures two signed two's-complement operands, A then B, from one shared group of data switches. A separate load switch steps the capture; the block then presents the held pair, with a valid flag, to the adder and its display decoders. It also drives state-indicator LEDs so the user knows which operand is expected next.

---
 rtl/board_pkg.sv | 33 +++
 rtl/sw_sync_filter.sv | 88 ++++++++
 rtl/operand_loader.sv | 156 +++++++++++++++
 tb/tb_operand_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the operand-entry stage.
//
// Contents:
//   DATA_W_DEF        default operand width (signed two's complement)
//   state_t           operand-entry FSM states {WAIT_A, WAIT_B, FULL}
//   LED_*             one-hot state indicator encodings
//   state_leds_of()   maps a state to its LED pattern
package board_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    localparam logic [2:0] LED_WAIT_A = 3'b001;
    localparam logic [2:0] LED_WAIT_B = 3'b010;
    localparam logic [2:0] LED_FULL   = 3'b100;

    function automatic logic [2:0] state_leds_of(input state_t s);
        logic [2:0] leds;
        case (s)
            WAIT_A:  leds = LED_WAIT_A;
            WAIT_B:  leds = LED_WAIT_B;
            FULL:    leds = LED_FULL;
            default: leds = LED_WAIT_A;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/sw_sync_filter.sv
// sw_sync_filter: conditions one raw control switch into a single-cycle
// rising-edge event.
//
// Build option: OPERAND_LOADER_DEBOUNCE_EN inserts a debounce filter between
// the synchroniser and the edge detector. Without it the filtered level is
// the synchronised level and no counter exists.
//
// Ports:
//   clk    in   board clock
//   reset  in   asynchronous active-low reset
//   sw     in   raw switch level
//   rise   out  one-cycle pulse on each filtered 0->1 transition
module sw_sync_filter
`ifdef OPERAND_LOADER_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic rise
);

    logic [1:0] sync_q;
    logic [1:0] prime_q;
    logic       armed_q;
    logic       prev_q;
    logic       level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sw};
        end
    end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // The filtered level flips only after the synchronised level has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing
    // cycle restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    // A switch already high when reset releases must not produce an event.
    // prime_q marks when the synchroniser holds real switch samples; only a
    // genuine low seen after that arms the edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_q <= '0;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
            armed_q <= armed_q | (prime_q[1] & ~sync_q[1]);
            prev_q  <= level;
        end
    end

    assign rise = level & ~prev_q & armed_q;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: sequential operand-entry stage feeding the signed adder.
// Captures operand A then operand B from one shared switch bus, stepped by
// a load switch; a clear switch returns to WAIT_A.
//
// Build option: OPERAND_LOADER_DEBOUNCE_EN enables debounce filtering of
// sw_load and sw_clear (DEBOUNCE_CYCLES stable cycles).
//
// Ports:
//   clk         in   board clock
//   reset       in   asynchronous active-low reset
//   sw_data     in   raw data switches (operand value)
//   sw_load     in   raw load switch; filtered rising edge captures
//   sw_clear    in   raw clear switch; filtered rising edge clears
//   op_a        out  operand A, registered, signed two's complement
//   op_b        out  operand B, registered, signed two's complement
//   op_valid    out  high while op_a/op_b hold a complete pair
//   pair_done   out  one-cycle pulse when B is captured
//   state_leds  out  one-hot state: WAIT_A=001, WAIT_B=010, FULL=100
//
// Output protocol: op_valid is a plain level qualifying op_a/op_b. The
// consumer is combinational and never acknowledges; the pair stays
// presented until the next load or clear changes it.
module operand_loader
    import board_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_load,
    input  logic              sw_clear,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    output logic              pair_done,
    output logic [2:0]        state_leds
);

    logic              load_ev;
    logic              clear_ev;
    logic [DATA_W-1:0] data_s1_q;
    logic [DATA_W-1:0] data_s2_q;

    state_t            state_q,    state_nxt;
    logic [DATA_W-1:0] op_a_q,     op_a_nxt;
    logic [DATA_W-1:0] op_b_q,     op_b_nxt;
    logic              valid_q,    valid_nxt;
    logic              pd_q,       pd_nxt;

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    sw_sync_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_load),
        .rise  (load_ev)
    );

    sw_sync_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_clear),
        .rise  (clear_ev)
    );
`else
    sw_sync_filter u_load (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_load),
        .rise  (load_ev)
    );

    sw_sync_filter u_clear (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_clear),
        .rise  (clear_ev)
    );
`endif

    // Data bus has the same two-stage depth as the load path, so the value
    // sampled on a load event is the one set alongside the load switch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            data_s1_q <= sw_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Next-state and operand update. Clear has priority over load.
    always_comb begin
        state_nxt = state_q;
        op_a_nxt  = op_a_q;
        op_b_nxt  = op_b_q;
        valid_nxt = valid_q;
        pd_nxt    = 1'b0;

        if (clear_ev) begin
            state_nxt = WAIT_A;
            op_a_nxt  = '0;
            op_b_nxt  = '0;
            valid_nxt = 1'b0;
        end else if (load_ev) begin
            case (state_q)
                WAIT_A: begin
                    op_a_nxt  = data_s2_q;
                    state_nxt = WAIT_B;
                end
                WAIT_B: begin
                    op_b_nxt  = data_s2_q;
                    valid_nxt = 1'b1;
                    pd_nxt    = 1'b1;
                    state_nxt = FULL;
                end
                FULL: begin
                    // Starting a new pair; op_b keeps the old value until
                    // the next B capture overwrites it.
                    op_a_nxt  = data_s2_q;
                    valid_nxt = 1'b0;
                    state_nxt = WAIT_B;
                end
                default: begin
                    state_nxt = WAIT_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
            pd_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            op_a_q  <= op_a_nxt;
            op_b_q  <= op_b_nxt;
            valid_q <= valid_nxt;
            pd_q    <= pd_nxt;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = valid_q;
    assign pair_done  = pd_q;
    assign state_leds = state_leds_of(state_q);

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized self-checking bench for operand_loader.
// Expected behaviour comes from a small abstract model (state number,
// operand values, valid flag) updated once per switch press.
module tb_operand_loader;

    localparam int W = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif
    localparam int LOW_CYC = LAT + 4;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sw_data = '0;
    logic         sw_load = 1'b0;
    logic         sw_clear = 1'b0;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic         pair_done;
    logic [2:0]   state_leds;

    always #5 clk = ~clk;

    operand_loader #(.DATA_W(W), .DEBOUNCE_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_data    (sw_data),
        .sw_load    (sw_load),
        .sw_clear   (sw_clear),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .pair_done  (pair_done),
        .state_leds (state_leds)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    // Model: m_st 0 = waiting for A, 1 = waiting for B, 2 = pair held.
    int           m_st = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_op_a"}, 32'(op_a), 32'(m_a));
        check({tag, "_op_b"}, 32'(op_b), 32'(m_b));
        check({tag, "_valid"}, 32'(op_valid), 32'(m_v));
        check({tag, "_leds"}, 32'(state_leds), 32'(3'b001 << m_st));
    endtask

    task automatic model_step(input bit ld, input bit clr, input logic [W-1:0] d, output bit pd);
        pd = 1'b0;
        if (clr) begin
            m_st = 0; m_a = '0; m_b = '0; m_v = 1'b0;
        end else if (ld) begin
            if (m_st == 0) begin
                m_a = d; m_st = 1;
            end else if (m_st == 1) begin
                m_b = d; m_v = 1'b1; m_st = 2; pd = 1'b1;
            end else begin
                m_a = d; m_v = 1'b0; m_st = 1;
            end
        end
    endtask

    // Every pair_done pulse must match a completed pair in the model.
    always @(posedge clk) begin
        #1;
        if (pair_done) begin
            if (exp_q.size() == 0) begin
                check("pd_unexpected", 32'(pair_done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pd_op_b", 32'(op_b), 32'(mon_e));
                check("pd_valid", 32'(op_valid), 32'd1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic press(input bit ld, input bit clr, input logic [W-1:0] d, input int hold);
        bit           pd;
        logic [W-1:0] o_a;
        int           o_st;
        o_a  = m_a;
        o_st = m_st;
        @(negedge clk);
        sw_data  = d;
        sw_load  = ld;
        sw_clear = clr;
        model_step(ld, clr, d, pd);
        if (pd) exp_q.push_back(d);
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk);
            #1;
            if (i == LAT - 1) begin
                check("pre_op_a", 32'(op_a), 32'(o_a));
                check("pre_leds", 32'(state_leds), 32'(3'b001 << o_st));
                check("pre_pd", 32'(pair_done), 32'd0);
            end
            if (i == LAT) begin
                check_all("post");
                check("edge_pd", 32'(pair_done), 32'(pd));
            end
        end
        repeat (hold + 1) @(posedge clk);
        #1;
        check_all("hold");
        @(negedge clk);
        sw_load  = 1'b0;
        sw_clear = 1'b0;
        repeat (LOW_CYC) @(posedge clk);
        #1;
        check_all("release");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  r;
        bit  ld;
        bit  clr;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_pd", 32'(pair_done), 32'd0);

        // Directed sequence: 3 then -2, then a new A of -8 from FULL.
        press(1, 0, 4'b0011, 1);
        press(1, 0, 4'b1110, 1);
        check("tp_op_a", 32'(op_a), 32'h3);
        check("tp_op_b", 32'(op_b), 32'hE);
        check("tp_valid", 32'(op_valid), 32'd1);
        check("tp_full", 32'(state_leds), 32'h4);
        press(1, 0, 4'b1000, 0);
        check("tp_new_a", 32'(op_a), 32'h8);
        check("tp_b_kept", 32'(op_b), 32'hE);
        check("tp_wait_b", 32'(state_leds), 32'h2);

        // Load and clear together while in WAIT_B: clear wins.
        press(1, 1, 4'b0101, 1);
        check("both_leds", 32'(state_leds), 32'h1);
        check("both_op_a", 32'(op_a), 32'h0);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
        // Short glitch is filtered out; a 20-cycle press captures at edge 19.
        @(negedge clk);
        sw_data = 4'b0110;
        sw_load = 1'b1;
        repeat (5) @(negedge clk);
        sw_load = 1'b0;
        repeat (LAT + 5) @(posedge clk);
        #1;
        check_all("glitch");
        press(1, 0, 4'b0110, 0);
        press(0, 1, 4'b0000, 0);
`endif

        // Randomized presses.
        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 9);
            ld  = (r < 7) || (r == 9);
            clr = (r >= 7);
            press(ld, clr, W'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Async reset in WAIT_B with load held high, released still high.
        press(0, 1, 4'b0000, 0);
        press(1, 0, 4'b0101, 0);
        @(negedge clk);
        sw_data = 4'b1001;
        sw_load = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        m_st = 0; m_a = '0; m_b = '0; m_v = 1'b0;
        #1;
        check_all("async_rst");
        check("async_rst_pd", 32'(pair_done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        check_all("rst_held_high");
        @(negedge clk);
        sw_load = 1'b0;
        repeat (LOW_CYC) @(posedge clk);
        press(1, 0, 4'b0111, 1);
        check("rearm_op_a", 32'(op_a), 32'h7);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
